// File: rtl/pixel_compositor_pkg.sv
// Shared definitions for the pixel compositor: sprite channel field layout,
// palette address constants and the sprite-0 forbidden column.
package pixel_compositor_pkg;

  // Width of one pixel / palette address and of one sprite channel slot
  localparam int PIX_W    = 5;
  localparam int SPR_CH_W = 5;

  // Sprite channel field offsets: {behind, palette[1:0], color[1:0]}
  localparam int SPR_BEHIND_BIT = 4;
  localparam int SPR_PAL_MSB    = 3;
  localparam int SPR_PAL_LSB    = 2;
  localparam int SPR_COL_MSB    = 1;
  localparam int SPR_COL_LSB    = 0;

  // Universal backdrop palette address
  localparam logic [PIX_W-1:0] BACKDROP = 5'b00000;

  // Palette address bit that selects the sprite half of the palette
  localparam int SPR_SRC_BIT = 4;

  // Column at which a sprite-0 hit can never be reported
  localparam int SPR0_FORBIDDEN_X = 255;

  // Selected sprite fields carried through the pipeline
  typedef struct packed {
    logic       behind;
    logic [1:0] palette;
    logic [1:0] color;
  } sprite_t;

  // Build the palette address for a sprite pixel
  function automatic logic [PIX_W-1:0] sprite_addr(input sprite_t spr);
    logic [PIX_W-1:0] addr;
    addr = {1'b0, spr.palette, spr.color};
    addr[SPR_SRC_BIT] = 1'b1;
    return addr;
  endfunction

endpackage

// File: rtl/pixel_compositor_sprite_priority_encoder.sv
// First-opaque search across the sprite channels. The lowest-index channel
// with a visible, nonzero color wins; its fields are returned unmodified.
module sprite_priority_encoder
  import pixel_compositor_pkg::*;
#(
  parameter int NUM_SPRITE_CH = 8
) (
  input  logic [SPR_CH_W*NUM_SPRITE_CH-1:0] sprite_i,
  input  logic                              show_i,
  output sprite_t                           winner_o,
  output logic                              spr_opaque_o,
  output logic                              ch0_opaque_o
);

  logic [SPR_CH_W-1:0]      ch_s [NUM_SPRITE_CH];
  logic [NUM_SPRITE_CH-1:0] opq_s;

  // Slice each channel out of the flat bus and flag it opaque if visible
  for (genvar k = 0; k < NUM_SPRITE_CH; k++) begin : g_ch
    assign ch_s[k]  = sprite_i[k*SPR_CH_W +: SPR_CH_W];
    assign opq_s[k] = show_i & (ch_s[k][SPR_COL_MSB:SPR_COL_LSB] != 2'b00);
  end

  assign ch0_opaque_o = opq_s[0];

  // Scan from the highest index down so the lowest opaque index is left standing
  always_comb begin
    winner_o     = '0;
    spr_opaque_o = 1'b0;
    for (int k = NUM_SPRITE_CH - 1; k >= 0; k--) begin
      if (opq_s[k]) begin
        winner_o.behind  = ch_s[k][SPR_BEHIND_BIT];
        winner_o.palette = ch_s[k][SPR_PAL_MSB:SPR_PAL_LSB];
        winner_o.color   = ch_s[k][SPR_COL_MSB:SPR_COL_LSB];
        spr_opaque_o     = 1'b1;
      end else begin
        winner_o     = winner_o;
        spr_opaque_o = spr_opaque_o;
      end
    end
  end

endmodule

// File: rtl/pixel_compositor.sv
// Two-stage pixel compositor: stage 1 masks background and sprites (left
// clipping, draw enables), picks the winning sprite and forms the sprite-0
// hit candidate; stage 2 resolves priority and maintains the sticky hit flag.
// Everything advances only on dot-enabled cycles.
module pixel_compositor
  import pixel_compositor_pkg::*;
#(
  parameter int NUM_SPRITE_CH = 8,
  parameter int CLIP_WIDTH    = 8,
  parameter int X_WIDTH       = 8
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              clock_EN,
  input  logic                              lineStart,
  input  logic                              frameStart,
  input  logic                              backgroundDraw_EN,
  input  logic                              spriteDraw_EN,
  input  logic                              bgLeftShow_EN,
  input  logic                              sprLeftShow_EN,
  input  logic                              debugCollisionOff,
  input  logic [PIX_W-1:0]                  backgroundPixel,
  input  logic [SPR_CH_W*NUM_SPRITE_CH-1:0] sprite_IN,
  output logic [PIX_W-1:0]                  pixel_OUT,
  output logic                              pixel_valid,
  output logic                              spriteZeroHit
);

  localparam logic [X_WIDTH-1:0] X_MAX = '1;

  // Column counter
  logic [X_WIDTH-1:0] x_q, x_d;
  logic [X_WIDTH-1:0] x_cur_s;

  // Stage 1 registers
  logic [PIX_W-1:0] s1_bg_q, s1_bg_d;
  logic             s1_bg_opaque_q, s1_bg_opaque_d;
  sprite_t          s1_spr_q, s1_spr_d;
  logic             s1_spr_opaque_q, s1_spr_opaque_d;
  logic             s1_hit_q, s1_hit_d;
  logic             s1_valid_q, s1_valid_d;

  // Stage 2 registers
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             valid_q, valid_d;
  logic             hit_q, hit_d;

  // Stage 1 combinational terms
  logic    in_clip_s;
  logic    bg_opaque_s;
  logic    spr_show_s;
  sprite_t winner_s;
  logic    spr_opaque_s;
  logic    ch0_opaque_s;
  logic    hit_cand_s;
  logic [PIX_W-1:0] pix_mux_s;

  sprite_priority_encoder #(
    .NUM_SPRITE_CH (NUM_SPRITE_CH)
  ) u_spr_enc (
    .sprite_i     (sprite_IN),
    .show_i       (spr_show_s),
    .winner_o     (winner_s),
    .spr_opaque_o (spr_opaque_s),
    .ch0_opaque_o (ch0_opaque_s)
  );

  // Current column and layer masking; lineStart makes this pixel column 0
  always_comb begin
    x_cur_s     = lineStart ? '0 : x_q;
    in_clip_s   = (int'(x_cur_s) < CLIP_WIDTH);
    bg_opaque_s = backgroundDraw_EN & ~(in_clip_s & ~bgLeftShow_EN)
                  & (backgroundPixel[SPR_COL_MSB:SPR_COL_LSB] != 2'b00);
    spr_show_s  = spriteDraw_EN & ~(in_clip_s & ~sprLeftShow_EN);
    hit_cand_s  = ch0_opaque_s & bg_opaque_s & ~debugCollisionOff
                  & (int'(x_cur_s) != SPR0_FORBIDDEN_X);
  end

  // Counter next state: lineStart reload beats saturation
  always_comb begin
    x_d = x_q;
    if (!clock_EN) begin
      x_d = x_q;
    end else if (lineStart) begin
      x_d = X_WIDTH'(1);
    end else if (x_q == X_MAX) begin
      x_d = X_MAX;
    end else begin
      x_d = x_q + X_WIDTH'(1);
    end
  end

  // Stage 1 next state: capture masked layers and hit candidate when enabled
  always_comb begin
    s1_bg_d         = s1_bg_q;
    s1_bg_opaque_d  = s1_bg_opaque_q;
    s1_spr_d        = s1_spr_q;
    s1_spr_opaque_d = s1_spr_opaque_q;
    s1_hit_d        = s1_hit_q;
    s1_valid_d      = s1_valid_q;
    if (clock_EN) begin
      s1_bg_d         = backgroundPixel;
      s1_bg_opaque_d  = bg_opaque_s;
      s1_spr_d        = winner_s;
      s1_spr_opaque_d = spr_opaque_s;
      s1_hit_d        = hit_cand_s;
      s1_valid_d      = 1'b1;
    end else begin
      s1_valid_d      = s1_valid_q;
    end
  end

  // Stage 2 priority mux between background, winning sprite and backdrop
  always_comb begin
    pix_mux_s = BACKDROP;
    case ({s1_bg_opaque_q, s1_spr_opaque_q})
      2'b00:   pix_mux_s = BACKDROP;
      2'b01:   pix_mux_s = sprite_addr(s1_spr_q);
      2'b10:   pix_mux_s = s1_bg_q;
      2'b11:   pix_mux_s = s1_spr_q.behind ? s1_bg_q : sprite_addr(s1_spr_q);
      default: pix_mux_s = BACKDROP;
    endcase
  end

  // Stage 2 next state: frameStart clear wins over a hit arriving this edge
  always_comb begin
    pix_d   = pix_q;
    valid_d = valid_q;
    hit_d   = hit_q;
    if (clock_EN) begin
      pix_d   = pix_mux_s;
      valid_d = s1_valid_q;
      if (frameStart) begin
        hit_d = 1'b0;
      end else if (s1_hit_q) begin
        hit_d = 1'b1;
      end else begin
        hit_d = hit_q;
      end
    end else begin
      hit_d = hit_q;
    end
  end

  // All state registers with asynchronous clear
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      x_q             <= '0;
      s1_bg_q         <= '0;
      s1_bg_opaque_q  <= 1'b0;
      s1_spr_q        <= '0;
      s1_spr_opaque_q <= 1'b0;
      s1_hit_q        <= 1'b0;
      s1_valid_q      <= 1'b0;
      pix_q           <= '0;
      valid_q         <= 1'b0;
      hit_q           <= 1'b0;
    end else begin
      x_q             <= x_d;
      s1_bg_q         <= s1_bg_d;
      s1_bg_opaque_q  <= s1_bg_opaque_d;
      s1_spr_q        <= s1_spr_d;
      s1_spr_opaque_q <= s1_spr_opaque_d;
      s1_hit_q        <= s1_hit_d;
      s1_valid_q      <= s1_valid_d;
      pix_q           <= pix_d;
      valid_q         <= valid_d;
      hit_q           <= hit_d;
    end
  end

  assign pixel_OUT     = pix_q;
  assign pixel_valid   = valid_q;
  assign spriteZeroHit = hit_q;

endmodule

// File: tb/tb_pixel_compositor.sv
// Directed bench for pixel_compositor: priority, clipping, sprite-0 hit,
// clear/hit ordering, dot-enable hold and asynchronous reset.
module tb_pixel_compositor;

  logic        clock;
  logic        reset_n;
  logic        clock_EN;
  logic        lineStart;
  logic        frameStart;
  logic        backgroundDraw_EN;
  logic        spriteDraw_EN;
  logic        bgLeftShow_EN;
  logic        sprLeftShow_EN;
  logic        debugCollisionOff;
  logic [4:0]  backgroundPixel;
  logic [39:0] sprite_IN;
  logic [4:0]  pixel_OUT;
  logic        pixel_valid;
  logic        spriteZeroHit;

  int n_asserts;
  int n_fail;

  localparam logic [4:0] T      = 5'b00000;
  localparam logic [4:0] HIT_BG = 5'b00110;
  localparam logic [4:0] HIT_S0 = 5'b00111;
  localparam logic [4:0] EXP_S0 = 5'b10111;
  localparam logic [4:0] BG_A   = 5'b01010;

  pixel_compositor #(
    .NUM_SPRITE_CH (8),
    .CLIP_WIDTH    (8),
    .X_WIDTH       (8)
  ) dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .clock_EN          (clock_EN),
    .lineStart         (lineStart),
    .frameStart        (frameStart),
    .backgroundDraw_EN (backgroundDraw_EN),
    .spriteDraw_EN     (spriteDraw_EN),
    .bgLeftShow_EN     (bgLeftShow_EN),
    .sprLeftShow_EN    (sprLeftShow_EN),
    .debugCollisionOff (debugCollisionOff),
    .backgroundPixel   (backgroundPixel),
    .sprite_IN         (sprite_IN),
    .pixel_OUT         (pixel_OUT),
    .pixel_valid       (pixel_valid),
    .spriteZeroHit     (spriteZeroHit)
  );

  // Free-running clock
  always #5 clock = ~clock;

  task automatic drive(input logic [4:0] bg, input logic [4:0] c0,
                       input logic [4:0] c1, input logic ls, input logic fs);
    backgroundPixel = bg;
    sprite_IN       = {30'b0, c1, c0};
    lineStart       = ls;
    frameStart      = fs;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [4:0] exp_pix;
    n_asserts         = 0;
    n_fail            = 0;
    clock             = 1'b0;
    reset_n           = 1'b0;
    clock_EN          = 1'b1;
    backgroundDraw_EN = 1'b1;
    spriteDraw_EN     = 1'b1;
    bgLeftShow_EN     = 1'b1;
    sprLeftShow_EN    = 1'b1;
    debugCollisionOff = 1'b1;
    drive(T, T, T, 1'b0, 1'b0);

    // Reset state
    #3;
    check("rst_pix", pixel_OUT, 5'b00000);
    check("rst_valid", pixel_valid, 1'b0);
    check("rst_hit", spriteZeroHit, 1'b0);
    tick();
    check("rst_x", dut.x_q, 8'd0);
    reset_n = 1'b1;

    // Walk to x = 20, then sprite in front of background
    drive(T, T, T, 1'b1, 1'b0); tick();
    for (int i = 0; i < 19; i++) begin drive(T, T, T, 1'b0, 1'b0); tick(); end
    check("x_at_20", dut.x_q, 8'd20);
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("prio_front", pixel_OUT, EXP_S0);
    check("valid_run", pixel_valid, 1'b1);
    check("dbg_off_nohit", spriteZeroHit, 1'b0);

    // Channel 0 behind wins selection over in-front channel 1
    drive(5'b00101, 5'b10011, 5'b01001, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("prio_behind", pixel_OUT, 5'b00101);

    // Channel 0 transparent: channel 1 in front wins
    drive(5'b00101, T, 5'b01001, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("prio_ch1", pixel_OUT, 5'b11001);

    // Sprite only
    drive(T, 5'b00110, T, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("spr_only", pixel_OUT, 5'b10110);

    // Background only, then backdrop
    drive(5'b01101, T, T, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("bg_only", pixel_OUT, 5'b01101);
    tick();
    check("backdrop", pixel_OUT, 5'b00000);

    // Background rendering disabled
    backgroundDraw_EN = 1'b0;
    drive(5'b01101, T, T, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("bg_disabled", pixel_OUT, 5'b00000);
    backgroundDraw_EN = 1'b1;

    // Left clip of background, x = 0..9
    bgLeftShow_EN = 1'b0;
    for (int k = 0; k < 10; k++) begin
      drive(BG_A, T, T, (k == 0), 1'b0); tick();
      if (k > 0) begin
        exp_pix = (k - 1 < 8) ? 5'b00000 : BG_A;
        check("clip_on", pixel_OUT, exp_pix);
      end
    end
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("clip_on_x9", pixel_OUT, BG_A);

    bgLeftShow_EN = 1'b1;
    for (int k = 0; k < 10; k++) begin
      drive(BG_A, T, T, (k == 0), 1'b0); tick();
      if (k > 0) check("clip_off", pixel_OUT, BG_A);
    end

    // Sprite clipped at x = 0 reveals the background
    sprLeftShow_EN = 1'b0;
    drive(BG_A, HIT_S0, T, 1'b1, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("spr_clip", pixel_OUT, BG_A);
    sprLeftShow_EN = 1'b1;

    // Sprite-0 hit at x = 100
    debugCollisionOff = 1'b0;
    drive(T, T, T, 1'b1, 1'b0); tick();
    for (int i = 0; i < 99; i++) begin drive(T, T, T, 1'b0, 1'b0); tick(); end
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    check("hit_stage1", spriteZeroHit, 1'b0);
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("hit_pix", pixel_OUT, EXP_S0);
    check("hit_set", spriteZeroHit, 1'b1);
    for (int i = 0; i < 50; i++) begin
      drive(T, T, T, 1'b0, 1'b0); tick();
      check("hit_sticky", spriteZeroHit, 1'b1);
    end

    // frameStart clears the flag on its own edge
    drive(T, T, T, 1'b0, 1'b1); tick();
    check("frame_clear", spriteZeroHit, 1'b0);

    // No hit at x = 255, including the saturated column after it
    drive(T, T, T, 1'b1, 1'b0); tick();
    for (int i = 0; i < 254; i++) begin drive(T, T, T, 1'b0, 1'b0); tick(); end
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    check("x255_pix", pixel_OUT, EXP_S0);
    check("x255_nohit", spriteZeroHit, 1'b0);
    check("x_saturated", dut.x_q, 8'd255);
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("xsat_nohit", spriteZeroHit, 1'b0);

    // lineStart beats saturation: pixel is column 0, so the hit counts
    drive(HIT_BG, HIT_S0, T, 1'b1, 1'b0); tick();
    check("ls_reload", dut.x_q, 8'd1);
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("ls_over_sat_hit", spriteZeroHit, 1'b1);

    // debugCollisionOff suppresses the hit
    drive(T, T, T, 1'b0, 1'b1); tick();
    debugCollisionOff = 1'b1;
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("dbg_nohit", spriteZeroHit, 1'b0);
    debugCollisionOff = 1'b0;

    // Clear versus hit on the same edge, then a hit one cycle later
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b1); tick();
    check("clear_wins", spriteZeroHit, 1'b0);
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("hit_after_clear", spriteZeroHit, 1'b1);

    // Dot-enable hold mid-line
    drive(BG_A, T, T, 1'b1, 1'b0); tick();
    drive(HIT_BG, HIT_S0, T, 1'b0, 1'b0); tick();
    check("pre_hold_pix", pixel_OUT, BG_A);
    check("pre_hold_x", dut.x_q, 8'd2);
    clock_EN = 1'b0;
    drive(5'b11111, 5'b11111, 5'b11111, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) tick();
    check("hold_pix", pixel_OUT, BG_A);
    check("hold_hit", spriteZeroHit, 1'b1);
    check("hold_valid", pixel_valid, 1'b1);
    check("hold_x", dut.x_q, 8'd2);
    clock_EN = 1'b1;
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("post_hold_pix", pixel_OUT, EXP_S0);
    check("post_hold_x", dut.x_q, 8'd3);

    // Asynchronous reset between clock edges
    reset_n = 1'b0;
    #2;
    check("arst_pix", pixel_OUT, 5'b00000);
    check("arst_valid", pixel_valid, 1'b0);
    check("arst_hit", spriteZeroHit, 1'b0);
    check("arst_x", dut.x_q, 8'd0);
    #2;
    reset_n = 1'b1;
    drive(BG_A, T, T, 1'b0, 1'b0); tick();
    check("valid_after_rst1", pixel_valid, 1'b0);
    drive(T, T, T, 1'b0, 1'b0); tick();
    check("valid_after_rst2", pixel_valid, 1'b1);
    check("pix_after_rst", pixel_OUT, BG_A);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_compositor.md
# pixel_compositor

Parametrised successor to the PPU pixel prioritiser. It merges one background pixel with NUM_SPRITE_CH sprite channels, applies left-column clipping, and resolves sprite-versus-background priority. It detects sprite-0 hits and latches the hit flag until the frame is cleared. It sits between the background/sprite shifters and the palette lookup, runs as a two-stage pipeline advanced by the dot-clock enable, and replaces the single-sprite combinational collision output.

## Interface
Parameters:
- NUM_SPRITE_CH, default 8: sprite channels. Channel 0 is always the sprite-0 channel. Legal range 1–8.
- CLIP_WIDTH, default 8: number of leftmost pixels masked by the left-show enables. Legal range 0–255.
- X_WIDTH, default 8: width of the internal pixel-column counter.

Ports (clock and reset first):
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- clock_EN  in  1  dot enable; the pipeline and counter advance only when high.
- lineStart  in  1  sampled when clock_EN is high; marks the current pixel as column 0.
- frameStart  in  1  sampled when clock_EN is high; clears spriteZeroHit.
- backgroundDraw_EN  in  1  background rendering enable.
- spriteDraw_EN  in  1  sprite rendering enable.
- bgLeftShow_EN  in  1  when low, background is transparent for x < CLIP_WIDTH.
- sprLeftShow_EN  in  1  when low, sprites are transparent for x < CLIP_WIDTH.
- debugCollisionOff  in  1  suppresses setting of spriteZeroHit.
- backgroundPixel  in  5  {palette[2:0], color[1:0]}; color 0 means transparent.
- sprite_IN  in  5*NUM_SPRITE_CH  channel k occupies bits [5k+4:5k] as {behind, palette[1:0], color[1:0]}.
- pixel_OUT  out  5  palette address: {1, spr palette, spr color} for a sprite, background value otherwise, 0 for backdrop.
- pixel_valid  out  1  high when pixel_OUT holds a pixel that has passed both pipeline stages.
- spriteZeroHit  out  1  sticky sprite-0 hit flag.

## Operation
- **Column counter x:**
  - On an enabled cycle with lineStart high, the current pixel is x = 0, and the counter loads 1 for the next pixel.
  - Otherwise the counter increments on each enabled cycle and saturates at 2^X_WIDTH − 1.
- **Masking (stage 1):**
  - Background is opaque only if backgroundDraw_EN is high, color ≠ 0, and not (x < CLIP_WIDTH with bgLeftShow_EN low).
  - Sprite channels are masked the same way using spriteDraw_EN and sprLeftShow_EN.
- **Sprite select (stage 1):**
  - The winner is the lowest-index channel with nonzero masked color.
  - The winner's behind bit decides priority, even when a higher-index opaque sprite is in front. This matches hardware behaviour.
  - sprOpaque = 1 when any masked sprite channel is opaque.
- **Mux (stage 2):**
  - Neither opaque: output 0 (universal backdrop).
  - Background transparent: output the sprite.
  - Sprite transparent: output the background.
  - Both opaque: output the sprite if behind = 0, otherwise the background.
- **Sprite-0 hit:**
  - The stage-1 candidate requires all of: masked channel 0 opaque (regardless of whether it wins), background opaque, x ≠ 255, and debugCollisionOff low.
  - The flag sets in stage 2 and stays high until frameStart.
- **Simultaneous events:**
  - frameStart and a hit on the same edge: clear wins, and the flag is 0.
  - lineStart takes precedence over saturation.
- **Reset (asserted at any time, including mid-line):** pixel_OUT = 0, pixel_valid = 0, spriteZeroHit = 0, x = 0, all pipeline registers = 0. Operation restarts with an empty pipeline.

## Timing
- Latency is two enabled cycles. Inputs sampled on enabled edge N appear on pixel_OUT after enabled edge N+1.
- The spriteZeroHit flag for that pixel rises on the same edge as its pixel_OUT.
- When clock_EN is low, all registers, outputs and x hold.
- pixel_valid goes high on the second enabled edge after reset and stays high.
- frameStart clears the flag on the same enabled edge at which it is sampled.

## Structure
- Shared package pixel_compositor_pkg:
  - sprite channel field offsets (behind = 4, palette = 3:2, color = 1:0);
  - backdrop constant 5'b0;
  - sprite-source bit position (4);
  - sprite-0 forbidden column (255).
- Sub-module sprite_priority_encoder:
  - parametrised by NUM_SPRITE_CH;
  - combinational first-opaque search;
  - returns the winner's fields and sprOpaque.

## Test plan
- **Priority, sprite in front:** bg = 5'b00110, ch0 = {0, 2'b01, 2'b11}, x = 20 -> pixel_OUT = 5'b10111 two enabled edges later.
- **Priority, sprite behind:** ch0 behind = 1 with color 3, ch1 = {0, 2'b10, 2'b01}, bg opaque 5'b00101 -> pixel_OUT = 5'b00101 (channel 0 wins selection and hides the background-priority case).
- **Left clip:**
  - bgLeftShow_EN = 0, bg opaque, no sprites, x = 0..9 -> pixel_OUT = 0 for x 0–7 and the bg value for x 8–9.
  - With bgLeftShow_EN = 1 -> the bg value at every x.
- **Sprite-0 hit:**
  - ch0 and bg opaque at x = 100 -> spriteZeroHit goes 1 with that pixel's output and holds through 50 later transparent pixels.
  - Same stimulus at x = 255, or with debugCollisionOff = 1 -> flag stays 0.
- **Clear versus hit:** frameStart on the edge where a hit reaches stage 2 -> flag 0. A hit one enabled cycle later -> flag 1.
- **Enable and reset:**
  - Hold clock_EN low for 5 cycles mid-line -> outputs and x unchanged.
  - Assert reset_n low asynchronously with spriteZeroHit = 1 -> all outputs read 0 before the next clock edge, and pixel_valid stays 0 for one enabled edge after release.
